// File: rtl/optimsoc_sram_pkg.sv
// Shared helpers and limits for the pipelined single-port SRAM and its response FIFO.
package optimsoc_sram_pkg;

  localparam int RSP_DEPTH_MAX = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Even parity: the stored bit makes the count of ones over byte plus bit even.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small circular response buffer; pointers wrap modulo DEPTH, push and pop may coincide when full.
module sram_rsp_fifo
  import optimsoc_sram_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; the head is read combinationally before the edge that overwrites it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/sram_sp_pipe.sv
// Single-port SRAM with ready/valid request and response channels and a fixed read latency.
// Define OPTIMSOC_SRAM_PARITY_EN to add per-byte even parity and the rsp_parity_err output.
module sram_sp_pipe
  import optimsoc_sram_pkg::*;
#(
  parameter int DW            = 32,
  parameter int AW            = 32,
  parameter int MEM_SIZE_BYTE = 'h8000,
  parameter int READ_LATENCY  = 1,
  parameter     MEM_FILE      = "sram.vmem",
  localparam int SW        = DW / 8,
  localparam int WORD_AW   = AW - clog2(SW),
  localparam int WORDS     = MEM_SIZE_BYTE / SW,
  localparam int RSP_DEPTH = READ_LATENCY + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [WORD_AW-1:0] req_waddr,
  input  logic [DW-1:0]      req_din,
  input  logic [SW-1:0]      req_sel,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DW-1:0]      rsp_dout,
  output logic               rsp_err
`ifdef OPTIMSOC_SRAM_PARITY_EN
  ,
  output logic               rsp_parity_err
`endif
);

  localparam int MEM_AW = (WORDS > 1) ? clog2(WORDS) : 1;
  localparam int CNT_W  = clog2(RSP_DEPTH_MAX + 1);
  localparam int PIPE_N = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;
`ifdef OPTIMSOC_SRAM_PARITY_EN
  localparam int RSP_W  = DW + 2;
`else
  localparam int RSP_W  = DW + 1;
`endif
  localparam int MEM_FILE_BITS_unused = $bits(MEM_FILE);

  logic [DW-1:0]     mem_q [WORDS];
  logic [MEM_AW-1:0] mem_idx;
  logic              in_bounds, accept, rd_accept, wr_accept, pop;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PIPE_N-1:0] pv_q, pv_d;
  logic [RSP_W-1:0]  pd_q [PIPE_N];
  logic [RSP_W-1:0]  pd_d [PIPE_N];
  logic [RSP_W-1:0]  rd_word, push_data, fifo_dout;
  logic              push, fifo_empty, fifo_full_unused;

  assign mem_idx   = req_waddr[MEM_AW-1:0];
  assign in_bounds = 64'(req_waddr) < 64'(WORDS);
  assign rsp_valid = !rst && !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;
  assign req_ready = !rst && ((cnt_q != CNT_W'(RSP_DEPTH)) || pop);
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_we;
  assign wr_accept = accept && req_we;

  always_ff @(posedge clk) begin
    if (wr_accept && in_bounds) begin
      for (int i = 0; i < SW; i++) begin
        if (req_sel[i]) mem_q[mem_idx][8*i +: 8] <= req_din[8*i +: 8];
      end
    end
  end

`ifdef OPTIMSOC_SRAM_PARITY_EN
  logic [SW-1:0] mem_par_q [WORDS];

  function automatic logic [SW-1:0] word_parity(input logic [DW-1:0] w);
    logic [SW-1:0] p;
    for (int i = 0; i < SW; i++) p[i] = byte_parity(w[8*i +: 8]);
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_accept && in_bounds) begin
      for (int i = 0; i < SW; i++) begin
        if (req_sel[i]) mem_par_q[mem_idx][i] <= byte_parity(req_din[8*i +: 8]);
      end
    end
  end
`endif

  // Response word layout: {parity error (optional), out-of-bounds error, data}.
  always_comb begin
    rd_word     = '0;
    rd_word[DW] = !in_bounds;
    if (in_bounds) rd_word[DW-1:0] = mem_q[mem_idx];
`ifdef OPTIMSOC_SRAM_PARITY_EN
    rd_word[DW+1] = in_bounds && (mem_par_q[mem_idx] != word_parity(mem_q[mem_idx]));
`endif
  end

  // The array is sampled in the acceptance cycle, then delayed so the FIFO sees it at t+READ_LATENCY-1.
  always_comb begin
    pv_d      = '0;
    pd_d      = pd_q;
    push      = rd_accept;
    push_data = rd_word;
    if (READ_LATENCY > 1) begin
      pv_d[0] = rd_accept;
      pd_d[0] = rd_word;
      for (int i = 1; i < PIPE_N; i++) begin
        pv_d[i] = pv_q[i-1];
        pd_d[i] = pd_q[i-1];
      end
      push      = pv_q[PIPE_N-1];
      push_data = pd_q[PIPE_N-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (rd_accept && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!rd_accept && pop) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      pv_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      pv_q  <= pv_d;
    end
  end

  always_ff @(posedge clk) begin
    pd_q <= pd_d;
  end

  sram_rsp_fifo #(
    .WIDTH(RSP_W),
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (push_data),
    .pop  (pop),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .full (fifo_full_unused)
  );

  assign rsp_dout = rsp_valid ? fifo_dout[DW-1:0] : '0;
  assign rsp_err  = rsp_valid && fifo_dout[DW];
`ifdef OPTIMSOC_SRAM_PARITY_EN
  assign rsp_parity_err = rsp_valid && fifo_dout[DW+1];
`endif

endmodule

// File: tb/tb_sram_sp_pipe.sv
// Bench for sram_sp_pipe (DW=32, 256-byte memory, READ_LATENCY=2): queue-based reference model plus directed checks.
module tb_sram_sp_pipe;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int MEMSZ = 'h100;
  localparam int LAT   = 2;
  localparam int DEPTH = LAT + 1;
  localparam int WORDS = 64;
  localparam int WAW   = 30;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_we = 1'b0;
  logic [WAW-1:0] req_waddr = '0;
  logic [31:0]    req_din = '0;
  logic [3:0]     req_sel = '0;
  logic           rsp_ready = 1'b1;
  logic           req_ready, rsp_valid, rsp_err;
  logic [31:0]    rsp_dout;
`ifdef OPTIMSOC_SRAM_PARITY_EN
  logic           rsp_parity_err;
  logic [3:0]     par_bad [WORDS];
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        perr;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mmem [WORDS];

  always #5 clk = ~clk;

  sram_sp_pipe #(
    .DW(DW), .AW(AW), .MEM_SIZE_BYTE(MEMSZ), .READ_LATENCY(LAT), .MEM_FILE("sram.vmem")
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_waddr(req_waddr), .req_din(req_din), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dout(rsp_dout), .rsp_err(rsp_err)
`ifdef OPTIMSOC_SRAM_PARITY_EN
    , .rsp_parity_err(rsp_parity_err)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic we, input logic [WAW-1:0] addr,
                               input logic [31:0] din, input logic [3:0] sel);
    req_valid = v;
    req_we    = we;
    req_waddr = addr;
    req_din   = din;
    req_sel   = sel;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request and holds it until accepted (bounded).
  task automatic sendReq(input logic we, input logic [WAW-1:0] addr, input logic [31:0] din, input logic [3:0] sel);
    logic accepted;
    accepted = 1'b0;
    applyStimulus(1'b1, we, addr, din, sel);
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      accepted = req_ready;
      tick();
    end
    checkOutput("req_accepted", {63'd0, accepted}, 64'd1);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Reads with sel=0 (the full word must still come back) and pins the response two cycles later.
  task automatic readCheck(input string name, input logic [WAW-1:0] addr, input logic [31:0] exp_data, input logic exp_err);
    sendReq(1'b0, addr, '0, 4'b0000);
    @(negedge clk);
    checkOutput({name, "_not_early"}, {63'd0, rsp_valid}, 64'd0);
    tick();
    @(negedge clk);
    checkOutput({name, "_valid"}, {63'd0, rsp_valid}, 64'd1);
    checkOutput({name, "_dout"}, {32'd0, rsp_dout}, {32'd0, exp_data});
    checkOutput({name, "_err"}, {63'd0, rsp_err}, {63'd0, exp_err});
    tick();
  endtask

  // Reference model: timestamped queue of expected responses, updated at each clock edge.
  always @(posedge clk) begin
    logic hv, rdy;
    int   idx;
    exp_t e;
    if (rst) begin
      q.delete();
    end else begin
      hv  = (q.size() > 0) && (q[0].cyc + LAT <= cyc);
      rdy = (q.size() < DEPTH) || (hv && rsp_ready);
      if (hv && rsp_ready) void'(q.pop_front());
      if (req_valid && rdy) begin
        idx = int'(req_waddr);
        if (req_we) begin
          if (idx < WORDS) begin
            for (int b = 0; b < 4; b++) begin
              if (req_sel[b]) begin
                mmem[idx][8*b +: 8] = req_din[8*b +: 8];
`ifdef OPTIMSOC_SRAM_PARITY_EN
                par_bad[idx][b] = 1'b0;
`endif
              end
            end
          end
        end else begin
          e.data = (idx < WORDS) ? mmem[idx] : 32'd0;
          e.err  = !(idx < WORDS);
          e.perr = 1'b0;
`ifdef OPTIMSOC_SRAM_PARITY_EN
          e.perr = (idx < WORDS) && (par_bad[idx] != 4'd0);
`endif
          e.cyc  = cyc;
          q.push_back(e);
        end
      end
    end
    cyc++;
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic ev, er;
    ev = !rst && (q.size() > 0) && (q[0].cyc + LAT <= cyc);
    er = !rst && ((q.size() < DEPTH) || (ev && rsp_ready));
    checkOutput("rsp_valid", {63'd0, rsp_valid}, {63'd0, ev});
    checkOutput("req_ready", {63'd0, req_ready}, {63'd0, er});
    if (ev) begin
      checkOutput("rsp_dout", {32'd0, rsp_dout}, {32'd0, q[0].data});
      checkOutput("rsp_err", {63'd0, rsp_err}, {63'd0, q[0].err});
`ifdef OPTIMSOC_SRAM_PARITY_EN
      checkOutput("rsp_parity_err", {63'd0, rsp_parity_err}, {63'd0, q[0].perr});
`endif
    end else if (rst) begin
      checkOutput("rst_dout", {32'd0, rsp_dout}, 64'd0);
      checkOutput("rst_err", {63'd0, rsp_err}, 64'd0);
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] exp_bp [4];
    int          got;
    exp_bp = '{32'h10000011, 32'h10000022, 32'h10000033, 32'h10000044};
`ifdef OPTIMSOC_SRAM_PARITY_EN
    for (int w = 0; w < WORDS; w++) par_bad[w] = 4'd0;
`endif

    // Reset: outputs quiet, then ready in the first cycle after release.
    repeat (3) tick();
    @(negedge clk);
    checkOutput("reset_req_ready", {63'd0, req_ready}, 64'd0);
    checkOutput("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", {63'd0, req_ready}, 64'd1);
    tick();

    for (int w = 0; w < WORDS; w++) sendReq(1'b1, WAW'(w), 32'h10000000 + 32'(w * 17), 4'hF);

    // Full write then read of the same word on the very next cycle.
    sendReq(1'b1, WAW'(5), 32'hDEADBEEF, 4'hF);
    readCheck("w5_full", WAW'(5), 32'hDEADBEEF, 1'b0);

    // Partial write touches only the low two bytes.
    sendReq(1'b1, WAW'(5), 32'h00001234, 4'b0011);
    checkOutput("model_w5", {32'd0, mmem[5]}, {32'd0, 32'hDEAD1234});
    readCheck("w5_partial", WAW'(5), 32'hDEAD1234, 1'b0);

    // Backpressure: DEPTH reads fill the response path, the next read must wait.
    rsp_ready = 1'b0;
    sendReq(1'b0, WAW'(1), '0, 4'b0000);
    sendReq(1'b0, WAW'(2), '0, 4'b0000);
    sendReq(1'b0, WAW'(3), '0, 4'b0000);
    applyStimulus(1'b1, 1'b0, WAW'(4), '0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_ready_low", {63'd0, req_ready}, 64'd0);
      tick();
    end
    got = 0;
    fork
      begin
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_ready_on_pop", {63'd0, req_ready}, 64'd1);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
      end
      begin
        for (int c = 0; c < 12 && got < 4; c++) begin
          @(negedge clk);
          if (rsp_valid) begin
            checkOutput("bp_order", {32'd0, rsp_dout}, {32'd0, exp_bp[got]});
            got++;
          end
        end
      end
    join
    checkOutput("bp_count", 64'(got), 64'd4);
    repeat (3) tick();

    // Out-of-bounds read and write.
    readCheck("oob_read", WAW'('h40), 32'h00000000, 1'b1);
    sendReq(1'b1, WAW'('h40), 32'hFFFFFFFF, 4'hF);
    readCheck("w0_after_oob", WAW'(0), 32'h10000000, 1'b0);
    for (int w = 1; w < WORDS; w++) sendReq(1'b0, WAW'(w), '0, 4'b0000);
    repeat (5) tick();

    // Reset one cycle after a read is accepted discards that read.
    sendReq(1'b0, WAW'(7), '0, 4'b0000);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_midrst", {63'd0, req_ready}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      checkOutput("no_rsp_after_rst", {63'd0, rsp_valid}, 64'd0);
      tick();
      @(negedge clk);
    end
    tick();

`ifdef OPTIMSOC_SRAM_PARITY_EN
    sendReq(1'b1, WAW'(3), 32'h0F0F0F0F, 4'hF);
    dut.mem_par_q[3][0] = ~dut.mem_par_q[3][0];
    par_bad[3][0] = 1'b1;
    sendReq(1'b0, WAW'(3), '0, 4'b0000);
    @(negedge clk);
    tick();
    @(negedge clk);
    checkOutput("parity_bad_w3", {63'd0, rsp_parity_err}, 64'd1);
    tick();
    sendReq(1'b0, WAW'(2), '0, 4'b0000);
    @(negedge clk);
    tick();
    @(negedge clk);
    checkOutput("parity_clean_w2", {63'd0, rsp_parity_err}, 64'd0);
    tick();
`endif

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_sp_pipe.md
SRAM_SP_PIPE -- requirements
Module: sram_sp_pipe

Interface
REQ-001 SHALL have parameter DW, default 32: data width in bits; multiple of 8, 8..128.
REQ-002 SHALL have parameter AW, default 32: byte address width.
REQ-003 SHALL have parameter MEM_SIZE_BYTE, default 'h8000: memory size in bytes; multiple of DW/8.
REQ-004 SHALL have parameter READ_LATENCY, default 1: cycles from read acceptance to rsp_valid; range 1..3.
REQ-005 SHALL have parameter MEM_FILE, default "sram.vmem": VMEM file loaded at simulation start.
REQ-006 SHALL derive localparams SW = DW/8, WORD_AW = AW - clog2(SW), WORDS = MEM_SIZE_BYTE/SW, RSP_DEPTH = READ_LATENCY+1.
REQ-007 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-008 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have port req_valid, input, 1: request present.
REQ-010 SHALL have port req_ready, output, 1: request accepted when req_valid && req_ready.
REQ-011 SHALL have port req_we, input, 1: 1 = write, 0 = read.
REQ-012 SHALL have port req_waddr, input, WORD_AW: word address.
REQ-013 SHALL have port req_din, input, DW: write data.
REQ-014 SHALL have port req_sel, input, SW: byte enables; bit i covers din[8i+7:8i].
REQ-015 SHALL have port rsp_valid, output, 1: read response present.
REQ-016 SHALL have port rsp_ready, input, 1: response consumed when rsp_valid && rsp_ready.
REQ-017 SHALL have port rsp_dout, output, DW: read data.
REQ-018 SHALL have port rsp_err, output, 1: response belongs to an out-of-bounds read.

Function
REQ-019 SHALL perform an accepted write in its acceptance cycle, updating only bytes with req_sel set; writes generate no response.
REQ-020 SHALL give a read accepted in cycle t rsp_valid no earlier than cycle t+READ_LATENCY, in acceptance order.
REQ-021 SHALL return, for a read accepted the cycle after a write to the same address, the written data (no stale read).
REQ-022 SHALL ignore req_sel on reads; the full word is returned.
REQ-023 SHALL track outstanding reads (in pipeline plus response FIFO) with a counter 0..RSP_DEPTH; a read accepted and a response consumed in the same cycle leave it unchanged.
REQ-024 SHALL drive req_ready = 0 when counter == RSP_DEPTH, unless a response is being consumed in that cycle; otherwise req_ready = 1, independent of req_we.
REQ-025 SHALL buffer read data in a RSP_DEPTH-entry FIFO so that rsp_ready held low never loses data; rsp_dout/rsp_err SHALL stay stable while rsp_valid && !rsp_ready.
REQ-026 SHALL treat a request as out-of-bounds when req_waddr >= WORDS: the write is dropped; a read returns rsp_dout = 0 with rsp_err = 1.
REQ-027 SHALL wrap FIFO read/write pointers modulo RSP_DEPTH; simultaneous push and pop on a full FIFO SHALL be legal.
REQ-028 SHALL leave the memory array contents unaffected by rst.

Reset
REQ-029 SHALL, while rst is high, drive rsp_valid = 0, rsp_err = 0, rsp_dout = 0 and req_ready = 0; the counter, pipeline valids and FIFO pointers SHALL clear.
REQ-030 SHALL discard reads in flight when rst asserts mid-operation; no response for them appears after reset.
REQ-031 SHALL assert req_ready = 1 in the first cycle after rst deasserts.

Configuration
REQ-032 SHALL, with OPTIMSOC_SRAM_PARITY_EN defined, store one even-parity bit per byte, add output rsp_parity_err (1 bit) and set it on a read whose stored parity mismatches; a write with partial sel SHALL update parity only for written bytes.
REQ-033 SHALL, without OPTIMSOC_SRAM_PARITY_EN, have no parity storage and no rsp_parity_err port.

Structure
REQ-034 SHALL keep helper function clog2 and localparam RSP_DEPTH_MAX = 4 in shared package optimsoc_sram_pkg.
REQ-035 SHALL implement the response buffer as sub-module sram_rsp_fifo (parameters WIDTH, DEPTH; ports clk, rst, push, din, pop, dout, empty, full).

Verification
REQ-036 SHALL verify: with DW=32, READ_LATENCY=2: write 0xDEADBEEF to word 5 with sel=4'b1111, then read word 5 -> rsp_valid 2 cycles later, rsp_dout=0xDEADBEEF.
REQ-037 SHALL verify: with word 5 = 0xDEADBEEF, write 0x00001234 with sel=4'b0011, then read -> 0xDEAD1234.
REQ-038 SHALL verify: with READ_LATENCY=1, rsp_ready=0 and 3 reads issued -> req_ready falls after the 2nd read; releasing rsp_ready delivers both responses in order and the 3rd read proceeds.
REQ-039 SHALL verify: with MEM_SIZE_BYTE='h100 and DW=32, read word 0x40 -> rsp_dout=0, rsp_err=1; write to word 0x40 leaves words 0..0x3F unchanged.
REQ-040 SHALL verify: rst asserted one cycle after a read acceptance -> no rsp_valid for that read; req_ready=1 the first cycle after rst.
REQ-041 SHALL verify: with OPTIMSOC_SRAM_PARITY_EN, force a stored parity bit flip on word 3, read word 3 -> rsp_parity_err=1; a clean read -> rsp_parity_err=0.
